noc_router_rr: RTL and testbench

//  Parametrised buffered router for the mesh: NUM_PORTS input channels, each with a FIFO.

---
 rtl/noc_router_rr.sv | 163 ++++++++++++++++
 tb/tb_noc_router_rr.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_router_rr.sv
// Buffered NUM_PORTS x NUM_PORTS router: per-input FIFO, per-output round-robin arbiter and output register.
// Define ROUTER_STATS_EN to add flit_count_o / drop_count_o statistics counters.

module noc_rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          gnt_o,
  output logic [IW-1:0] idx_o
);
  logic [IW-1:0] cand;

  // First requester at or after ptr_i, wrapping at N (N need not be a power of 2).
  always_comb begin
    gnt_o = 1'b0;
    idx_o = '0;
    cand  = ptr_i;
    for (int k = 0; k < N; k++) begin
      if (!gnt_o && req_i[cand]) begin
        gnt_o = 1'b1;
        idx_o = cand;
      end
      cand = (cand == IW'(N-1)) ? '0 : cand + 1'b1;
    end
  end
endmodule

module noc_router_rr #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 8,
  parameter int PORT_W     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clock_i,
  input  logic                                reset_ni,
  input  logic [NUM_PORTS*(PORT_W+DATA_W)-1:0] in_flit_i,
  input  logic [NUM_PORTS-1:0]                in_valid_i,
  output logic [NUM_PORTS-1:0]                in_ready_o,
  output logic [NUM_PORTS*(PORT_W+DATA_W)-1:0] out_flit_o,
  output logic [NUM_PORTS-1:0]                out_valid_o,
  input  logic [NUM_PORTS-1:0]                out_ready_i,
  input  logic [NUM_PORTS-1:0]                block_paths_i,
`ifdef ROUTER_STATS_EN
  output logic [NUM_PORTS*16-1:0]             flit_count_o,
  output logic [15:0]                         drop_count_o,
`endif
  output logic [NUM_PORTS-1:0]                fifo_full_o
);
  localparam int FLIT_W = PORT_W + DATA_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int IW     = $clog2(NUM_PORTS);

  typedef logic [FLIT_W-1:0] flit_t;

  flit_t [NUM_PORTS-1:0][FIFO_DEPTH-1:0]  mem_q;
  logic  [NUM_PORTS-1:0][AW:0]            wptr_q, rptr_q;
  flit_t [NUM_PORTS-1:0]                  head, out_flit_q, out_flit_d;
  logic  [NUM_PORTS-1:0]                  empty, full, push, pop, bad, can_load, gnt;
  logic  [NUM_PORTS-1:0]                  out_valid_q, out_valid_d;
  logic  [NUM_PORTS-1:0][NUM_PORTS-1:0]   req;
  logic  [NUM_PORTS-1:0][IW-1:0]          rr_ptr_q, rr_ptr_d, gnt_idx;

  // FIFO status and head decode; pointers carry an extra wrap bit to tell full from empty.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      empty[i]      = (wptr_q[i] == rptr_q[i]);
      full[i]       = (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]) && (wptr_q[i][AW] != rptr_q[i][AW]);
      head[i]       = mem_q[i][rptr_q[i][AW-1:0]];
      bad[i]        = !empty[i] && (32'(head[i][FLIT_W-1 -: PORT_W]) >= 32'(NUM_PORTS));
      in_ready_o[i] = reset_ni && !full[i];
      push[i]       = in_valid_i[i] && in_ready_o[i];
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      can_load[o] = !out_valid_q[o] || out_ready_i[o];
      for (int i = 0; i < NUM_PORTS; i++)
        req[o][i] = !empty[i] && !bad[i] && !block_paths_i[o] && can_load[o] &&
                    (head[i][FLIT_W-1 -: PORT_W] == PORT_W'(o));
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    noc_rr_arb #(.N(NUM_PORTS), .IW(IW)) u_arb (
      .req_i (req[o]),
      .ptr_i (rr_ptr_q[o]),
      .gnt_o (gnt[o]),
      .idx_o (gnt_idx[o])
    );
  end

  // Bad-destination heads are dropped; winners move into their output slot.
  always_comb begin
    pop         = bad;
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    rr_ptr_d    = rr_ptr_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (out_valid_q[o] && out_ready_i[o]) out_valid_d[o] = 1'b0;
      if (gnt[o]) begin
        pop[gnt_idx[o]] = 1'b1;
        out_valid_d[o]  = 1'b1;
        out_flit_d[o]   = head[gnt_idx[o]];
        rr_ptr_d[o]     = (gnt_idx[o] == IW'(NUM_PORTS-1)) ? '0 : gnt_idx[o] + 1'b1;
      end
    end
  end

  // Storage needs no reset: in_ready_o is low during reset so nothing is written.
  always_ff @(posedge clock_i) begin
    for (int i = 0; i < NUM_PORTS; i++)
      if (push[i]) mem_q[i][wptr_q[i][AW-1:0]] <= in_flit_i[i*FLIT_W +: FLIT_W];
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      out_valid_q <= '0;
      out_flit_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
        if (pop[i])  rptr_q[i] <= rptr_q[i] + 1'b1;
      end
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_flit_o  = out_flit_q;
  assign out_valid_o = out_valid_q;
  assign fifo_full_o = full;

`ifdef ROUTER_STATS_EN
  logic [NUM_PORTS-1:0][15:0] flit_cnt_q;
  logic [15:0]                drop_cnt_q, drop_inc;

  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < NUM_PORTS; i++) drop_inc = drop_inc + 16'(bad[i]);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      flit_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++)
        if (out_valid_q[o] && out_ready_i[o]) flit_cnt_q[o] <= flit_cnt_q[o] + 1'b1;
      drop_cnt_q <= drop_cnt_q + drop_inc;
    end
  end

  assign flit_count_o = flit_cnt_q;
  assign drop_count_o = drop_cnt_q;
`endif
endmodule

// File: tb/tb_noc_router_rr.sv
// Bench for noc_router_rr: vector table, directed corner sequences, and random traffic vs a queue model.
module tb_noc_router_rr;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  iv = '0, ir, ordy = '0, blk = '0, ov, ff;
  logic [39:0] ifl = '0, ofl;
  logic [2:0]  iv3 = '0, ir3, ordy3 = 3'b111, blk3 = '0, ov3, ff3;
  logic [29:0] ifl3 = '0, ofl3;
`ifdef ROUTER_STATS_EN
  logic [63:0] fc;
  logic [15:0] dc;
  logic [47:0] fc3;
  logic [15:0] dc3;
`endif

  noc_router_rr #(.NUM_PORTS(4), .DATA_W(8), .PORT_W(2), .FIFO_DEPTH(4)) dut (
    .clock_i(clk), .reset_ni(rstn), .in_flit_i(ifl), .in_valid_i(iv), .in_ready_o(ir),
    .out_flit_o(ofl), .out_valid_o(ov), .out_ready_i(ordy), .block_paths_i(blk),
`ifdef ROUTER_STATS_EN
    .flit_count_o(fc), .drop_count_o(dc),
`endif
    .fifo_full_o(ff));

  noc_router_rr #(.NUM_PORTS(3), .DATA_W(8), .PORT_W(2), .FIFO_DEPTH(4)) dut3 (
    .clock_i(clk), .reset_ni(rstn), .in_flit_i(ifl3), .in_valid_i(iv3), .in_ready_o(ir3),
    .out_flit_o(ofl3), .out_valid_o(ov3), .out_ready_i(ordy3), .block_paths_i(blk3),
`ifdef ROUTER_STATS_EN
    .flit_count_o(fc3), .drop_count_o(dc3),
`endif
    .fifo_full_o(ff3));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: per-input queues, per-output slot ----------------
  typedef logic [9:0] fl_t;
  fl_t  mq[4][$];
  logic [3:0] m_v;
  fl_t  m_f[4];
  int   m_ptr[4];
  int   m_fc[4];
  bit   model_on = 0;

  function automatic logic [3:0] m_ir();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = rstn && (mq[i].size() < 4);
    return r;
  endfunction

  task automatic model_update();
    int win[4];
    logic [3:0] acc;
    acc = m_ir();
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        mq[i].delete(); m_f[i] = '0; m_ptr[i] = 0; m_fc[i] = 0;
      end
      m_v = '0;
      return;
    end
    for (int o = 0; o < 4; o++) begin
      win[o] = -1;
      if ((!m_v[o] || ordy[o]) && !blk[o])
        for (int k = 0; k < 4; k++) begin
          int i;
          i = (m_ptr[o] + k) % 4;
          if (win[o] < 0 && mq[i].size() > 0 && int'(mq[i][0][9:8]) == o) win[o] = i;
        end
    end
    for (int o = 0; o < 4; o++)
      if (m_v[o] && ordy[o]) begin m_v[o] = 1'b0; m_fc[o] = (m_fc[o] + 1) % 65536; end
    for (int o = 0; o < 4; o++)
      if (win[o] >= 0) begin
        m_f[o] = mq[win[o]].pop_front(); m_v[o] = 1'b1; m_ptr[o] = (win[o] + 1) % 4;
      end
    for (int i = 0; i < 4; i++)
      if (iv[i] && acc[i]) mq[i].push_back(ifl[i*10 +: 10]);
  endtask

  task automatic m_check();
    logic [39:0] ef;
    logic [3:0]  eff;
    for (int o = 0; o < 4; o++) begin ef[o*10 +: 10] = m_f[o]; eff[o] = (mq[o].size() == 4); end
    chk("model out_valid", ov, m_v);
    chk("model out_flit", ofl, ef);
    chk("model in_ready", ir, m_ir());
    chk("model fifo_full", ff, eff);
`ifdef ROUTER_STATS_EN
    for (int o = 0; o < 4; o++) chk("model flit_count", fc[o*16 +: 16], m_fc[o]);
    chk("model drop_count", dc, 0);
`endif
  endtask

  // Called at a negedge with inputs driven; returns at the next negedge.
  task automatic step();
    #1;
    if (model_on) m_check();
    @(posedge clk);
    if (model_on) model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0; iv = '0; iv3 = '0;
    step();
    rstn = 1'b1;
  endtask

  function automatic logic [39:0] fl(int p, logic [9:0] f);
    logic [39:0] r;
    r = '0;
    r[p*10 +: 10] = f;
    return r;
  endfunction

  typedef struct {
    logic [3:0]  iv;
    logic [39:0] ifl;
    logic [3:0]  ordy, blk, ev;
    logic [39:0] ef;
  } vec_t;
  vec_t tbl[14];

  initial begin
    int k;
    logic acc;
    logic [39:0] hold;

    // single hop, then block with pending flit, then block rising over an occupied slot
    hold = fl(3, 10'h3A5);
    tbl[0]  = '{4'b0001, fl(0, 10'h3A5), 4'hF, 4'h0, 4'h0, 40'h0};
    tbl[1]  = '{4'b0000, 40'h0,          4'hF, 4'h0, 4'h0, 40'h0};
    tbl[2]  = '{4'b0000, 40'h0,          4'hF, 4'h0, 4'b1000, hold};
    tbl[3]  = '{4'b0010, fl(1, 10'h05C), 4'hF, 4'b0001, 4'h0, hold};
    tbl[4]  = '{4'b0000, 40'h0,          4'hF, 4'b0001, 4'h0, hold};
    tbl[5]  = '{4'b0000, 40'h0,          4'hF, 4'b0001, 4'h0, hold};
    tbl[6]  = '{4'b0000, 40'h0,          4'hF, 4'h0, 4'h0, hold};
    tbl[7]  = '{4'b0000, 40'h0,          4'hF, 4'h0, 4'b0001, hold | fl(0, 10'h05C)};
    tbl[8]  = '{4'b0000, 40'h0,          4'hF, 4'h0, 4'h0, hold | fl(0, 10'h05C)};
    tbl[9]  = '{4'b0100, fl(2, 10'h011), 4'h0, 4'h0, 4'h0, hold | fl(0, 10'h05C)};
    tbl[10] = '{4'b0000, 40'h0,          4'h0, 4'h0, 4'h0, hold | fl(0, 10'h05C)};
    tbl[11] = '{4'b0000, 40'h0,          4'h0, 4'b0001, 4'b0001, hold | fl(0, 10'h011)};
    tbl[12] = '{4'b0000, 40'h0,          4'hF, 4'b0001, 4'b0001, hold | fl(0, 10'h011)};
    tbl[13] = '{4'b0000, 40'h0,          4'hF, 4'h0, 4'h0, hold | fl(0, 10'h011)};

    // reset state
    @(negedge clk); #1;
    chk("in_ready during reset", ir, 4'h0);
    @(posedge clk);
    model_update();
    model_on = 1;
    @(negedge clk);
    chk("reset out_valid", ov, 4'h0);
    chk("reset out_flit", ofl, 40'h0);
    chk("reset fifo_full", ff, 4'h0);
    rstn = 1'b1;
    #1 chk("in_ready after reset", ir, 4'hF);

    for (int r = 0; r < 14; r++) begin
      iv = tbl[r].iv; ifl = tbl[r].ifl; ordy = tbl[r].ordy; blk = tbl[r].blk;
      chk($sformatf("tbl[%0d] out_valid", r), ov, tbl[r].ev);
      chk($sformatf("tbl[%0d] out_flit", r), ofl, tbl[r].ef);
      chk($sformatf("tbl[%0d] in_ready", r), ir, 4'hF);
      step();
    end

    // contention: 3 flits per input to out1, released together
    do_reset();
    ordy = 4'hF; blk = 4'b0010;
    for (int s = 0; s < 3; s++) begin
      iv = 4'hF;
      for (int i = 0; i < 4; i++) ifl[i*10 +: 10] = {2'd1, 4'(i), 4'(s)};
      step();
    end
    iv = '0; blk = '0;
    step();
    for (int n = 0; n < 12; n++) begin
      chk($sformatf("rr valid %0d", n), ov[1], 1'b1);
      chk($sformatf("rr order %0d", n), ofl[19:10], {2'd1, 4'(n % 4), 4'(n / 4)});
      step();
    end
    chk("rr drained", ov[1], 1'b0);

    // backpressure on out2
    do_reset();
    ordy = 4'b1011; blk = '0; k = 0;
    for (int c = 0; c < 8; c++) begin
      iv = 4'b0010;
      ifl = fl(1, {2'd2, 8'h30 + 8'(k)});
      #1 acc = ir[1];
      step();
      if (acc) k++;
    end
    iv = '0;
    chk("bp accepted count", k, 5);
    chk("bp fifo_full", ff[1], 1'b1);
    chk("bp in_ready", ir[1], 1'b0);
    chk("bp slot valid", ov[2], 1'b1);
    ordy = 4'hF;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("bp drain valid %0d", j), ov[2], 1'b1);
      chk($sformatf("bp drain flit %0d", j), ofl[29:20], {2'd2, 8'h30 + 8'(j)});
      step();
    end
    chk("bp drained", ov[2], 1'b0);

    // reset mid-stream
    ordy = '0;
    for (int s = 0; s < 3; s++) begin
      iv = 4'hF;
      for (int i = 0; i < 4; i++) ifl[i*10 +: 10] = {2'(i), 8'hC0 + 8'(s)};
      step();
    end
    iv = '0; rstn = 1'b0;
    #1 chk("mid reset in_ready", ir, 4'h0);
    step();
    chk("mid reset out_valid", ov, 4'h0);
    chk("mid reset fifo_full", ff, 4'h0);
`ifdef ROUTER_STATS_EN
    chk("mid reset flit_count", fc, 64'h0);
    chk("mid reset drop_count", dc, 16'h0);
`endif
    rstn = 1'b1; ordy = 4'hF;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("no stale %0d", c), ov, 4'h0);
    end

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rstn = ($urandom_range(0, 149) != 0);
      iv   = 4'($urandom);
      ifl  = {8'($urandom), $urandom};
      ordy = 4'($urandom | $urandom);
      blk  = 4'($urandom & $urandom & $urandom);
      step();
    end
    rstn = 1'b1; iv = '0; ordy = 4'hF; blk = '0;
    for (int c = 0; c < 10; c++) step();

    // 3-port router: bad dst is dropped without output
    ordy3 = 3'b111;
    iv3 = 3'b001; ifl3 = {20'h0, 2'd3, 8'hEE};
    step();
    chk("drop c0 out_valid", ov3, 3'b000);
    ifl3 = {20'h0, 2'd2, 8'h70};
    step();
    chk("drop c1 out_valid", ov3, 3'b000);
    ifl3 = {20'h0, 2'd2, 8'h71};
    step();
    chk("drop first good valid", ov3, 3'b100);
    chk("drop first good flit", ofl3[29:20], 10'h270);
    ifl3 = {20'h0, 2'd2, 8'h72};
    step();
    chk("drop second good flit", ofl3[29:20], 10'h271);
    iv3 = '0;
    step();
    chk("drop third good flit", ofl3[29:20], 10'h272);
    step();
    chk("drop drained", ov3, 3'b000);
`ifdef ROUTER_STATS_EN
    chk("stats flit_count[2]", fc3[47:32], 16'd3);
    chk("stats drop_count", dc3, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
